bf_in_xbar: RTL and testbench

- Parametrised, pipelined crossbar between the NTT/poly-mul memory banks and the butterfly array.
- Routes 2*NUM_BF bank read words to the u/v operands of NUM_BF butterflies.
- Per-source select is registered to align with the 1-cycle bank read latency.
- Adds per-source enable, a valid pipeline, hold-on-unassigned destinations (no latches), registered outputs and routing-conflict detection.

---
 rtl/bf_in_xbar.sv | 89 ++++++++
 tb/tb_bf_in_xbar.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_in_xbar.sv
// rtl/bf_in_xbar.sv - pipelined bank-to-butterfly operand crossbar with conflict detection
module bf_in_xbar #(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_BF     = 4,
    parameter int SEL_W      = $clog2(2*NUM_BF)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [2*NUM_BF*SEL_W-1:0]        sel,
    input  logic [2*NUM_BF-1:0]              sel_en,
    input  logic [2*NUM_BF*DATA_WIDTH-1:0]   q,
    input  logic                             clr_err,
    output logic [NUM_BF*DATA_WIDTH-1:0]     u,
    output logic [NUM_BF*DATA_WIDTH-1:0]     v,
    output logic                             out_valid,
    output logic [2*NUM_BF-1:0]              dest_upd,
    output logic                             conflict,
    output logic                             conflict_sticky
);

    localparam int NUM_LANES = 2*NUM_BF;

    logic [NUM_LANES*SEL_W-1:0] sel_r;
    logic [NUM_LANES-1:0]       en_r;
    logic                       vld_r;

    logic [DATA_WIDTH-1:0]      dst [NUM_LANES];
    logic [DATA_WIDTH-1:0]      nxt [NUM_LANES];
    logic [NUM_LANES-1:0]       hit;
    logic                       multi;

    // Ascending source scan: the last match seen is the highest index, which wins.
    always_comb begin
        hit   = '0;
        multi = 1'b0;
        for (int d = 0; d < NUM_LANES; d++) begin
            nxt[d] = dst[d];
            for (int i = 0; i < NUM_LANES; i++) begin
                if (en_r[i] && (sel_r[i*SEL_W +: SEL_W] == SEL_W'(d))) begin
                    if (hit[d]) begin
                        multi = 1'b1;
                    end
                    hit[d] = 1'b1;
                    nxt[d] = q[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_r           <= '0;
            en_r            <= '0;
            vld_r           <= 1'b0;
            out_valid       <= 1'b0;
            dest_upd        <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            for (int d = 0; d < NUM_LANES; d++) begin
                dst[d] <= '0;
            end
        end else begin
            sel_r     <= sel;
            en_r      <= sel_en;
            vld_r     <= in_valid;
            out_valid <= vld_r;
            dest_upd  <= vld_r ? hit : '0;
            conflict  <= vld_r & multi;
            if (vld_r) begin
                for (int d = 0; d < NUM_LANES; d++) begin
                    dst[d] <= nxt[d];
                end
            end
            // A new conflict outranks a simultaneous clear.
            if (vld_r && multi) begin
                conflict_sticky <= 1'b1;
            end else if (clr_err) begin
                conflict_sticky <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_BF; k++) begin : g_out
        assign u[k*DATA_WIDTH +: DATA_WIDTH] = dst[2*k];
        assign v[k*DATA_WIDTH +: DATA_WIDTH] = dst[2*k+1];
    end

endmodule

// File: tb/tb_bf_in_xbar.sv
// tb/tb_bf_in_xbar.sv - randomized self-checking bench for bf_in_xbar
module tb_bf_in_xbar;

    localparam int DW = 256;
    localparam int NB = 4;
    localparam int NL = 2*NB;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [NL*SW-1:0]  sel;
    logic [NL-1:0]     sel_en;
    logic [NL*DW-1:0]  q;
    logic              clr_err;
    logic [NB*DW-1:0]  u, v;
    logic              out_valid;
    logic [NL-1:0]     dest_upd;
    logic              conflict, conflict_sticky;

    bf_in_xbar #(.DATA_WIDTH(DW), .NUM_BF(NB), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .sel_en(sel_en),
        .q(q), .clr_err(clr_err), .u(u), .v(v), .out_valid(out_valid),
        .dest_upd(dest_upd), .conflict(conflict), .conflict_sticky(conflict_sticky)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0]    m_dst [NL];
    logic             m_sticky, e_ov, e_conf;
    logic [NL-1:0]    e_upd;
    logic             p_vld;
    logic [NL*SW-1:0] p_sel;
    logic [NL-1:0]    p_en;
    logic [NB*DW-1:0] exp_u, exp_v;

    function automatic logic [NL*SW-1:0] sel_ident();
        logic [NL*SW-1:0] s;
        for (int i = 0; i < NL; i++) s[i*SW +: SW] = SW'(i);
        return s;
    endfunction

    function automatic logic [NL*SW-1:0] sel_rev();
        logic [NL*SW-1:0] s;
        for (int i = 0; i < NL; i++) s[i*SW +: SW] = SW'(NL-1-i);
        return s;
    endfunction

    function automatic logic [NL*DW-1:0] rand_q();
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL*DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NL; d++) m_dst[d] = '0;
        m_sticky = 0; e_ov = 0; e_conf = 0; e_upd = '0;
        p_vld = 0; p_sel = '0; p_en = '0; exp_u = '0; exp_v = '0;
    endtask

    // Drives one cycle of inputs, advances the model across the next edge, then waits for it.
    task automatic drive_cycle(input logic vld, input logic [NL*SW-1:0] s,
                               input logic [NL-1:0] en, input logic [NL*DW-1:0] qq,
                               input logic clr);
        int best, n;
        in_valid = vld; sel = s; sel_en = en; q = qq; clr_err = clr;
        e_ov = p_vld; e_upd = '0; e_conf = 0;
        if (p_vld) begin
            for (int d = 0; d < NL; d++) begin
                best = -1; n = 0;
                for (int i = NL-1; i >= 0; i--) begin
                    if (p_en[i] && p_sel[i*SW +: SW] == SW'(d)) begin
                        n++;
                        if (best < 0) best = i;
                    end
                end
                if (best >= 0) begin
                    m_dst[d] = qq[best*DW +: DW];
                    e_upd[d] = 1'b1;
                end
                if (n > 1) e_conf = 1'b1;
            end
        end
        if (e_conf) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        p_vld = vld; p_sel = s; p_en = en;
        for (int k = 0; k < NB; k++) begin
            exp_u[k*DW +: DW] = m_dst[2*k];
            exp_v[k*DW +: DW] = m_dst[2*k+1];
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 0; in_valid = 0; sel = '0; sel_en = '0; q = '0; clr_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({u, v} !== '0) begin miscompares++; $display("FAIL reset_uv got nonzero %0d want 0", $countones({u, v})); end
        vectors++;
        if ({out_valid, dest_upd, conflict, conflict_sticky} !== 11'h0)
            begin miscompares++; $display("FAIL reset_ctl got %h want 000", {out_valid, dest_upd, conflict, conflict_sticky}); end
        rst = 1;
    endtask

    task automatic test_identity();
        logic [NL*DW-1:0] qq;
        for (int i = 0; i < NL; i++) qq[i*DW +: DW] = DW'(i+1);
        drive_cycle(1, sel_ident(), 8'hFF, rand_q(), 0);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL identity_early_valid got %b want 0", out_valid); end
        drive_cycle(0, '0, '0, qq, 0);
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (u[k*DW +: DW] !== DW'(2*k+1)) begin miscompares++; $display("FAIL identity_u%0d got %h want %h", k, u[k*DW +: DW], 2*k+1); end
            vectors++;
            if (v[k*DW +: DW] !== DW'(2*k+2)) begin miscompares++; $display("FAIL identity_v%0d got %h want %h", k, v[k*DW +: DW], 2*k+2); end
        end
        vectors++;
        if ({out_valid, dest_upd, conflict} !== {1'b1, 8'hFF, 1'b0})
            begin miscompares++; $display("FAIL identity_ctl got %h want %h", {out_valid, dest_upd, conflict}, {1'b1, 8'hFF, 1'b0}); end
    endtask

    task automatic test_back_to_back();
        logic [NL*DW-1:0] q1, q2;
        q1 = rand_q(); q2 = rand_q();
        drive_cycle(1, sel_ident(), 8'hFF, rand_q(), 0);
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive_cycle(1, sel_rev(), 8'hFF, q1, 0);
            else        drive_cycle(0, '0, '0, q2, 0);
            for (int k = 0; k < NB; k++) begin
                vectors++;
                if (u[k*DW +: DW] !== exp_u[k*DW +: DW]) begin miscompares++; $display("FAIL b2b_u%0d got %h want %h", k, u[k*DW +: DW], exp_u[k*DW +: DW]); end
                vectors++;
                if (v[k*DW +: DW] !== exp_v[k*DW +: DW]) begin miscompares++; $display("FAIL b2b_v%0d got %h want %h", k, v[k*DW +: DW], exp_v[k*DW +: DW]); end
            end
            vectors++;
            if ({out_valid, dest_upd, conflict, conflict_sticky} !== {e_ov, e_upd, e_conf, m_sticky})
                begin miscompares++; $display("FAIL b2b_ctl got %h want %h", {out_valid, dest_upd, conflict, conflict_sticky}, {e_ov, e_upd, e_conf, m_sticky}); end
        end
        vectors++;
        if (u[0 +: DW] !== q2[7*DW +: DW]) begin miscompares++; $display("FAIL b2b_u0_is_q7 got %h want %h", u[0 +: DW], q2[7*DW +: DW]); end
        vectors++;
        if (v[3*DW +: DW] !== q2[0 +: DW]) begin miscompares++; $display("FAIL b2b_v3_is_q0 got %h want %h", v[3*DW +: DW], q2[0 +: DW]); end
    endtask

    task automatic test_partial_enable();
        logic [NL*SW-1:0] s;
        logic [NL*DW-1:0] qq;
        logic [NB*DW-1:0] prev_u, prev_v;
        prev_u = u; prev_v = v;
        s = {($urandom), ($urandom)};
        s[0 +: SW] = 3'd3; s[5*SW +: SW] = 3'd0;
        qq = rand_q();
        qq[0 +: DW] = DW'(8'hAA); qq[5*DW +: DW] = DW'(8'h55);
        drive_cycle(1, s, 8'b0010_0001, rand_q(), 0);
        drive_cycle(0, '0, '0, qq, 0);
        vectors++;
        if (u[0 +: DW] !== DW'(8'h55)) begin miscompares++; $display("FAIL partial_u0 got %h want 55", u[0 +: DW]); end
        vectors++;
        if (v[DW +: DW] !== DW'(8'hAA)) begin miscompares++; $display("FAIL partial_v1 got %h want aa", v[DW +: DW]); end
        for (int k = 1; k < NB; k++) begin
            vectors++;
            if (u[k*DW +: DW] !== prev_u[k*DW +: DW]) begin miscompares++; $display("FAIL partial_hold_u%0d got %h want %h", k, u[k*DW +: DW], prev_u[k*DW +: DW]); end
        end
        vectors++;
        if (v[0 +: DW] !== prev_v[0 +: DW]) begin miscompares++; $display("FAIL partial_hold_v0 got %h want %h", v[0 +: DW], prev_v[0 +: DW]); end
        vectors++;
        if ({out_valid, dest_upd, conflict} !== {1'b1, 8'h09, 1'b0})
            begin miscompares++; $display("FAIL partial_ctl got %h want %h", {out_valid, dest_upd, conflict}, {1'b1, 8'h09, 1'b0}); end
    endtask

    task automatic test_conflict();
        logic [NL*SW-1:0] s;
        logic [NL*DW-1:0] qq;
        s = sel_ident();
        s[2*SW +: SW] = 3'd4; s[6*SW +: SW] = 3'd4;
        qq = rand_q();
        qq[2*DW +: DW] = DW'(8'h22); qq[6*DW +: DW] = DW'(8'h66);
        // steps: set, data, idle, clear, set, data+clear on the conflict edge
        for (int st = 0; st < 6; st++) begin
            case (st)
                0, 4:    drive_cycle(1, s, 8'b0100_0100, rand_q(), 0);
                1:       drive_cycle(0, '0, '0, qq, 0);
                2:       drive_cycle(0, '0, '0, rand_q(), 0);
                3:       drive_cycle(0, '0, '0, rand_q(), 1);
                default: drive_cycle(0, '0, '0, qq, 1);
            endcase
            for (int k = 0; k < NB; k++) begin
                vectors++;
                if (u[k*DW +: DW] !== exp_u[k*DW +: DW]) begin miscompares++; $display("FAIL conflict_u%0d step %0d got %h want %h", k, st, u[k*DW +: DW], exp_u[k*DW +: DW]); end
                vectors++;
                if (v[k*DW +: DW] !== exp_v[k*DW +: DW]) begin miscompares++; $display("FAIL conflict_v%0d step %0d got %h want %h", k, st, v[k*DW +: DW], exp_v[k*DW +: DW]); end
            end
            vectors++;
            if ({out_valid, dest_upd, conflict, conflict_sticky} !== {e_ov, e_upd, e_conf, m_sticky})
                begin miscompares++; $display("FAIL conflict_ctl step %0d got %h want %h", st, {out_valid, dest_upd, conflict, conflict_sticky}, {e_ov, e_upd, e_conf, m_sticky}); end
        end
        vectors++;
        if (conflict_sticky !== 1'b1) begin miscompares++; $display("FAIL conflict_set_wins got %b want 1", conflict_sticky); end
        drive_cycle(0, '0, '0, rand_q(), 1);
        vectors++;
        if ({conflict, conflict_sticky} !== 2'b00) begin miscompares++; $display("FAIL conflict_clear got %b want 00", {conflict, conflict_sticky}); end
    endtask

    task automatic test_hold();
        logic [NB*DW-1:0] hu, hv;
        drive_cycle(0, '0, '0, rand_q(), 0);
        hu = u; hv = v;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(0, {$urandom, $urandom}, NL'($urandom), rand_q(), 0);
            vectors++;
            if ({u, v} !== {hu, hv}) begin miscompares++; $display("FAIL hold_uv cycle %0d got changed want held (%0d bits differ)", c, $countones({u, v} ^ {hu, hv})); end
            vectors++;
            if ({out_valid, dest_upd, conflict} !== 10'h0) begin miscompares++; $display("FAIL hold_ctl cycle %0d got %h want 000", c, {out_valid, dest_upd, conflict}); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 80; c++) begin
            drive_cycle(($urandom % 4) != 0, {$urandom, $urandom}, NL'($urandom),
                        rand_q(), ($urandom % 6) == 0);
            for (int k = 0; k < NB; k++) begin
                vectors++;
                if (u[k*DW +: DW] !== exp_u[k*DW +: DW]) begin miscompares++; $display("FAIL random_u%0d cycle %0d got %h want %h", k, c, u[k*DW +: DW], exp_u[k*DW +: DW]); end
                vectors++;
                if (v[k*DW +: DW] !== exp_v[k*DW +: DW]) begin miscompares++; $display("FAIL random_v%0d cycle %0d got %h want %h", k, c, v[k*DW +: DW], exp_v[k*DW +: DW]); end
            end
            vectors++;
            if ({out_valid, dest_upd, conflict, conflict_sticky} !== {e_ov, e_upd, e_conf, m_sticky})
                begin miscompares++; $display("FAIL random_ctl cycle %0d got %h want %h", c, {out_valid, dest_upd, conflict, conflict_sticky}, {e_ov, e_upd, e_conf, m_sticky}); end
        end
    endtask

    task automatic test_reset_mid_stream();
        drive_cycle(1, sel_ident(), 8'hFF, rand_q(), 0);
        drive_cycle(1, sel_rev(), 8'hFF, rand_q(), 0);
        rst = 0; in_valid = 0;
        #1;
        model_reset();
        vectors++;
        if ({u, v} !== '0) begin miscompares++; $display("FAIL midrst_uv got nonzero %0d want 0", $countones({u, v})); end
        vectors++;
        if ({out_valid, dest_upd, conflict, conflict_sticky} !== 11'h0)
            begin miscompares++; $display("FAIL midrst_ctl got %h want 000", {out_valid, dest_upd, conflict, conflict_sticky}); end
        @(posedge clk); #1;
        rst = 1;
        for (int c = 0; c < 4; c++) begin
            drive_cycle(0, {$urandom, $urandom}, NL'($urandom), rand_q(), 0);
            vectors++;
            if ({out_valid, dest_upd, conflict, conflict_sticky} !== 11'h0)
                begin miscompares++; $display("FAIL midrst_after_ctl cycle %0d got %h want 000", c, {out_valid, dest_upd, conflict, conflict_sticky}); end
            vectors++;
            if ({u, v} !== '0) begin miscompares++; $display("FAIL midrst_after_uv cycle %0d got nonzero %0d want 0", c, $countones({u, v})); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_partial_enable();
        test_conflict();
        test_hold();
        test_random();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
